// File: rtl/shift_xfer_ctrl_pkg.sv
// Shared definitions for the shift transfer controller: FSM state encoding
// and shift-direction constants.
package shift_xfer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Direction encoding: left moves MSB out and sdi into LSB, right moves
  // LSB out and sdi into MSB.
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_xfer_ctrl_shift_reg.sv
// Bidirectional shift register with parallel load and async active-low clear.
// Load has priority over shift. sout is the bit currently at the outgoing end
// for the selected direction.
module bidir_shift_reg_p
  import shift_xfer_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             shift_en_i,
  input  logic             dir_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Next register value: parallel load, shift in the chosen direction, or hold.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_data_i;
    end else if (shift_en_i) begin
      if (dir_i == DIR_RIGHT) begin
        q_d = {sin_i, q_q[WIDTH-1:1]};
      end else begin
        q_d = {q_q[WIDTH-2:0], sin_i};
      end
    end else begin
      q_d = q_q;
    end
  end

  // Register storage with asynchronous clear.
  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o    = q_q;
  assign sout_o = (dir_i == DIR_RIGHT) ? q_q[0] : q_q[WIDTH-1];

endmodule

// File: rtl/shift_xfer_ctrl.sv
// Transfer sequencer around a bidirectional shift register. One request
// (word, direction, bit count) is latched in IDLE, loaded, shifted out on sdo
// at clk/DIV while sdi is captured, and the resulting register contents are
// returned on rx_data with a one-cycle done pulse.
module shift_xfer_ctrl
  import shift_xfer_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] len,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             abort,
  input  logic             sdi,
  output logic             ready,
  output logic             busy,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);

  localparam int               DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);

  state_e           state_q, state_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WIDTH-1:0] rx_q, rx_d;

  logic [CNT_W-1:0] eff_len_s;
  logic             shift_tick_s;
  logic             last_bit_s;
  logic             sr_load_s;
  logic [WIDTH-1:0] sr_q_s;
  logic             sr_sout_s;
  logic [WIDTH-1:0] sr_next_s;

  // A zero or oversize request means a full-width transfer.
  assign eff_len_s = ((len == '0) || (len > WIDTH_C)) ? WIDTH_C : len;

  // Shift happens on the last clock of each bit period, unless aborting.
  assign shift_tick_s = (state_q == ST_SHIFT) && (div_q == DIV_LAST) && !abort;
  assign last_bit_s   = (bit_q == (len_q - CNT_W'(1)));
  assign sr_load_s    = (state_q == ST_LOAD);

  // Register value after the final shift, captured as rx_data entering DONE.
  assign sr_next_s = (dir_q == DIR_RIGHT) ? {sdi, sr_q_s[WIDTH-1:1]}
                                          : {sr_q_s[WIDTH-2:0], sdi};

  bidir_shift_reg_p #(
    .WIDTH (WIDTH)
  ) u_sr (
    .clk_i       (clk),
    .clr_ni      (reset_n),
    .load_i      (sr_load_s),
    .load_data_i (tx_q),
    .shift_en_i  (shift_tick_s),
    .dir_i       (dir_q),
    .sin_i       (sdi),
    .q_o         (sr_q_s),
    .sout_o      (sr_sout_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; start wins over abort in IDLE, abort is ignored in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_LOAD;
        else       state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (abort) state_d = ST_IDLE;
        else       state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (abort)                           state_d = ST_IDLE;
        else if (shift_tick_s && last_bit_s) state_d = ST_DONE;
        else                                 state_d = ST_SHIFT;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register.
  always_comb begin
    ready     = 1'b0;
    sdo_valid = 1'b0;
    done      = 1'b0;
    sdo       = 1'b0;
    case (state_q)
      ST_IDLE:  ready = 1'b1;
      ST_LOAD:  ready = 1'b0;
      ST_SHIFT: begin
        sdo_valid = 1'b1;
        sdo       = sr_sout_s;
      end
      ST_DONE:  done = 1'b1;
      default:  ready = 1'b0;
    endcase
    busy = ~ready;
  end

  // Request latch, taken only when a start is accepted in IDLE.
  always_comb begin
    dir_d = dir_q;
    len_d = len_q;
    tx_d  = tx_q;
    if ((state_q == ST_IDLE) && start) begin
      dir_d = dir;
      len_d = eff_len_s;
      tx_d  = tx_data;
    end else begin
      dir_d = dir_q;
      len_d = len_q;
      tx_d  = tx_q;
    end
  end

  // Bit and divider counters: cleared in LOAD, saturate at the last bit.
  always_comb begin
    bit_d = bit_q;
    div_d = div_q;
    case (state_q)
      ST_LOAD: begin
        bit_d = '0;
        div_d = '0;
      end
      ST_SHIFT: begin
        if (abort) begin
          bit_d = bit_q;
          div_d = div_q;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          bit_d = last_bit_s ? bit_q : (bit_q + CNT_W'(1));
        end else begin
          div_d = div_q + DIV_W'(1);
          bit_d = bit_q;
        end
      end
      default: begin
        bit_d = bit_q;
        div_d = div_q;
      end
    endcase
  end

  // Result capture on the final shift, i.e. on entry to DONE.
  always_comb begin
    rx_d = rx_q;
    if (shift_tick_s && last_bit_s) rx_d = sr_next_s;
    else                            rx_d = rx_q;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dir_q <= DIR_LEFT;
      len_q <= '0;
      tx_q  <= '0;
      bit_q <= '0;
      div_q <= '0;
      rx_q  <= '0;
    end else begin
      dir_q <= dir_d;
      len_q <= len_d;
      tx_q  <= tx_d;
      bit_q <= bit_d;
      div_q <= div_d;
      rx_q  <= rx_d;
    end
  end

  assign rx_data = rx_q;

endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// Directed bench for shift_xfer_ctrl: one DUT with DIV=1 and one with DIV=3.
module tb_shift_xfer_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start1, start3;
  logic       dir;
  logic [3:0] len;
  logic [7:0] tx;
  logic       abort;
  logic       loop_en;
  logic       sdi_drv;
  logic       sdi1, sdi3;
  logic       ready1, busy1, sdo1, sv1, done1;
  logic       ready3, busy3, sdo3, sv3, done3;
  logic [7:0] rx1, rx3;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] last_rx1;

  always #5 clk = ~clk;

  assign sdi1 = loop_en ? sdo1 : sdi_drv;
  assign sdi3 = loop_en ? sdo3 : sdi_drv;

  shift_xfer_ctrl #(.WIDTH(8), .DIV(1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .dir(dir), .len(len),
    .tx_data(tx), .abort(abort), .sdi(sdi1), .ready(ready1), .busy(busy1),
    .sdo(sdo1), .sdo_valid(sv1), .done(done1), .rx_data(rx1)
  );

  shift_xfer_ctrl #(.WIDTH(8), .DIV(3)) u_d3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .dir(dir), .len(len),
    .tx_data(tx), .abort(abort), .sdi(sdi3), .ready(ready3), .busy(busy3),
    .sdo(sdo3), .sdo_valid(sv3), .done(done3), .rx_data(rx3)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse start on DUT1 for one cycle; returns in cycle 1 (LOAD).
  task automatic kick1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  // Advance until DUT1 done or budget; cyc is the cycle number reached.
  task automatic wait_done1(input int budget, output int cyc);
    cyc = 1;
    while (!done1 && cyc < budget) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset;
    n_vec++;
    if ({ready1, busy1, done1, sdo1, sv1, rx1} !== {5'b10000, 8'h00}) begin
      n_err++;
      $display("FAIL reset_d1: got %b_%h expected 10000_00", {ready1, busy1, done1, sdo1, sv1}, rx1);
    end
    n_vec++;
    if ({ready3, busy3, done3, sdo3, sv3, rx3} !== {5'b10000, 8'h00}) begin
      n_err++;
      $display("FAIL reset_d3: got %b_%h expected 10000_00", {ready3, busy3, done3, sdo3, sv3}, rx3);
    end
  endtask

  task automatic test_loop_left;
    logic [7:0] exp_bits;
    exp_bits = 8'b1011_0001;
    tx = 8'hB1; dir = 1'b0; len = 4'd8; loop_en = 1'b1;
    kick1();
    n_vec++;
    if ({ready1, busy1, sv1, done1} !== 4'b0100) begin
      n_err++;
      $display("FAIL left_load: got %b expected 0100", {ready1, busy1, sv1, done1});
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if ({sv1, sdo1, done1} !== {1'b1, exp_bits[7-i], 1'b0}) begin
        n_err++;
        $display("FAIL left_sdo[%0d]: got %b expected %b", i, {sv1, sdo1, done1}, {1'b1, exp_bits[7-i], 1'b0});
      end
    end
    tick();
    n_vec++;
    if ({done1, rx1} !== {1'b1, 8'hB1}) begin
      n_err++;
      $display("FAIL left_done10: got %b/%h expected 1/b1", done1, rx1);
    end
    tick();
    n_vec++;
    if ({done1, ready1} !== 2'b01) begin
      n_err++;
      $display("FAIL left_after: got %b expected 01", {done1, ready1});
    end
    last_rx1 = 8'hB1;
  endtask

  task automatic test_loop_right;
    logic [7:0] exp_bits;
    int cyc;
    exp_bits = 8'b1000_1101;
    tx = 8'hB1; dir = 1'b1; len = 4'd8; loop_en = 1'b1;
    kick1();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if ({sv1, sdo1} !== {1'b1, exp_bits[7-i]}) begin
        n_err++;
        $display("FAIL right_sdo[%0d]: got %b expected %b", i, {sv1, sdo1}, {1'b1, exp_bits[7-i]});
      end
    end
    tick();
    n_vec++;
    if ({done1, rx1} !== {1'b1, 8'hB1}) begin
      n_err++;
      $display("FAIL right_done: got %b/%h expected 1/b1", done1, rx1);
    end
    tick();
    last_rx1 = 8'hB1;
  endtask

  task automatic test_partial;
    int cyc;
    // left by 4 with zeros
    tx = 8'hB1; dir = 1'b0; len = 4'd4; loop_en = 1'b0; sdi_drv = 1'b0;
    kick1(); wait_done1(40, cyc);
    n_vec++;
    if (cyc !== 6 || rx1 !== 8'h10) begin
      n_err++;
      $display("FAIL partial_l4: got cyc %0d rx %h expected cyc 6 rx 10", cyc, rx1);
    end
    tick();
    // right by 3 with ones
    tx = 8'hB1; dir = 1'b1; len = 4'd3; sdi_drv = 1'b1;
    kick1(); wait_done1(40, cyc);
    n_vec++;
    if (cyc !== 5 || rx1 !== 8'hF6) begin
      n_err++;
      $display("FAIL partial_r3: got cyc %0d rx %h expected cyc 5 rx f6", cyc, rx1);
    end
    tick();
    // len=0 is a full 8-bit transfer
    tx = 8'h6D; dir = 1'b0; len = 4'd0; sdi_drv = 1'b0;
    kick1(); wait_done1(40, cyc);
    n_vec++;
    if (cyc !== 10 || rx1 !== 8'h00) begin
      n_err++;
      $display("FAIL len0: got cyc %0d rx %h expected cyc 10 rx 00", cyc, rx1);
    end
    tick();
    // len>8 is a full 8-bit transfer
    tx = 8'hB1; dir = 1'b1; len = 4'd15; loop_en = 1'b1;
    kick1(); wait_done1(40, cyc);
    n_vec++;
    if (cyc !== 10 || rx1 !== 8'hB1) begin
      n_err++;
      $display("FAIL len15: got cyc %0d rx %h expected cyc 10 rx b1", cyc, rx1);
    end
    tick();
    last_rx1 = 8'hB1;
  endtask

  task automatic test_div3;
    logic [7:0] exp_bits;
    exp_bits = 8'b1011_0001;
    tx = 8'hB1; dir = 1'b0; len = 4'd8; loop_en = 1'b1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      n_vec++;
      if ({sv3, sdo3, done3} !== {1'b1, exp_bits[7 - i/3], 1'b0}) begin
        n_err++;
        $display("FAIL div3_sdo[%0d]: got %b expected %b", i, {sv3, sdo3, done3}, {1'b1, exp_bits[7 - i/3], 1'b0});
      end
    end
    tick();
    n_vec++;
    if ({done3, rx3} !== {1'b1, 8'hB1}) begin
      n_err++;
      $display("FAIL div3_done26: got %b/%h expected 1/b1", done3, rx3);
    end
    tick();
  endtask

  task automatic test_abort;
    tx = 8'h5A; dir = 1'b0; len = 4'd8; loop_en = 1'b0; sdi_drv = 1'b0;
    start1 = 1'b1;
    tick();                 // cycle 1, start kept high while busy
    tx = 8'h00;
    n_vec++;
    if (busy1 !== 1'b1) begin
      n_err++;
      $display("FAIL abort_busy: got %b expected 1", busy1);
    end
    tick();                 // cycle 2
    start1 = 1'b0;
    tick();                 // cycle 3
    tick();                 // cycle 4, third bit
    n_vec++;
    if (sv1 !== 1'b1) begin
      n_err++;
      $display("FAIL abort_shift: got %b expected 1", sv1);
    end
    abort = 1'b1;
    tick();                 // cycle 5
    abort = 1'b0;
    n_vec++;
    if ({ready1, busy1, done1, sv1, rx1} !== {4'b1000, last_rx1}) begin
      n_err++;
      $display("FAIL abort_idle: got %b/%h expected 1000/%h", {ready1, busy1, done1, sv1}, rx1, last_rx1);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if ({ready1, done1} !== 2'b10) begin
        n_err++;
        $display("FAIL abort_quiet[%0d]: got %b expected 10", i, {ready1, done1});
      end
    end
    // start and abort together in IDLE: start wins, abort in LOAD cancels
    start1 = 1'b1; abort = 1'b1;
    tick();
    start1 = 1'b0;
    n_vec++;
    if (busy1 !== 1'b1) begin
      n_err++;
      $display("FAIL start_abort_accept: got %b expected 1", busy1);
    end
    tick();
    abort = 1'b0;
    n_vec++;
    if ({ready1, done1, rx1} !== {2'b10, last_rx1}) begin
      n_err++;
      $display("FAIL load_abort: got %b/%h expected 10/%h", {ready1, done1}, rx1, last_rx1);
    end
    tick();
  endtask

  task automatic test_back_to_back;
    int cyc;
    tx = 8'hB1; dir = 1'b0; len = 4'd8; loop_en = 1'b1;
    start1 = 1'b1;
    tick();
    cyc = 1;
    tx = 8'h5A; dir = 1'b1; len = 4'd2;
    while (!done1 && cyc < 40) begin
      if (cyc == 5) start1 = 1'b0;
      tick();
      cyc++;
    end
    start1 = 1'b0;
    n_vec++;
    if (cyc !== 10 || rx1 !== 8'hB1) begin
      n_err++;
      $display("FAIL busy_start_ignored: got cyc %0d rx %h expected cyc 10 rx b1", cyc, rx1);
    end
    tick();
    n_vec++;
    if (ready1 !== 1'b1) begin
      n_err++;
      $display("FAIL no_queue: got ready %b expected 1", ready1);
    end
    loop_en = 1'b0; sdi_drv = 1'b0;
    kick1(); wait_done1(40, cyc);
    n_vec++;
    if (cyc !== 4 || rx1 !== 8'h16) begin
      n_err++;
      $display("FAIL second_xfer: got cyc %0d rx %h expected cyc 4 rx 16", cyc, rx1);
    end
    tick();
  endtask

  task automatic test_reset_mid;
    int cyc;
    tx = 8'hB1; dir = 1'b0; len = 4'd8; loop_en = 1'b1;
    kick1();
    tick(); tick(); tick();  // cycle 4, sdo expected 1
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if ({ready1, busy1, done1, sv1, sdo1, rx1} !== {5'b10000, 8'h00}) begin
      n_err++;
      $display("FAIL mid_reset: got %b/%h expected 10000/00", {ready1, busy1, done1, sv1, sdo1}, rx1);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tx = 8'h3C; dir = 1'b0; len = 4'd2; loop_en = 1'b0; sdi_drv = 1'b1;
    kick1(); wait_done1(40, cyc);
    n_vec++;
    if (cyc !== 4 || rx1 !== 8'hF3) begin
      n_err++;
      $display("FAIL post_reset_xfer: got cyc %0d rx %h expected cyc 4 rx f3", cyc, rx1);
    end
    tick();
  endtask

  initial begin
    reset_n = 1'b0; start1 = 1'b0; start3 = 1'b0; dir = 1'b0; len = 4'd0;
    tx = 8'h00; abort = 1'b0; loop_en = 1'b0; sdi_drv = 1'b0;
    last_rx1 = 8'h00;
    #12;
    test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    test_loop_left();
    test_loop_right();
    test_partial();
    test_div3();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
